// File: rtl/wb_stage_pkg.sv
// Shared constants for the writeback stage: datapath widths, result-select
// codes and the load funct3 encodings understood by the load extender.
package wb_stage_pkg;

    localparam int WORD_LEN      = 32;
    localparam int REG_IDX_WIDTH = 5;

    // Result select codes carried down the pipe from decode
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_IMM  = 2'b11;

    // Load funct3 encodings; anything else is an illegal load
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_extender.sv
// Load extender: picks the addressed byte/halfword out of the raw aligned
// data-memory word, sign- or zero-extends it, and flags misaligned or
// illegal load encodings. Purely combinational.
module load_extender
    import wb_stage_pkg::*;
(
    input  logic [WORD_LEN-1:0] rawWord,
    input  logic [2:0]          funct3,
    input  logic [1:0]          addrLow,
    output logic [WORD_LEN-1:0] extData,
    output logic                misalign
);

    // Sign-extend or zero-extend a byte to the full word
    function automatic logic [WORD_LEN-1:0] extendByte(input logic [7:0] b, input logic isSigned);
        logic signed [7:0]          sb;
        logic signed [WORD_LEN-1:0] sw;
        sb = b;
        sw = sb;
        return isSigned ? sw : {{(WORD_LEN-8){1'b0}}, b};
    endfunction

    // Sign-extend or zero-extend a halfword to the full word
    function automatic logic [WORD_LEN-1:0] extendHalf(input logic [15:0] h, input logic isSigned);
        logic signed [15:0]         sh;
        logic signed [WORD_LEN-1:0] sw;
        sh = h;
        sw = sh;
        return isSigned ? sw : {{(WORD_LEN-16){1'b0}}, h};
    endfunction

    logic [WORD_LEN-1:0] byteShifted;
    logic [WORD_LEN-1:0] halfShifted;

    // Lane selection by shifting the addressed byte/half down to bit 0
    always_comb begin
        byteShifted = rawWord >> {addrLow, 3'b000};
        halfShifted = rawWord >> {addrLow[1], 4'b0000};
    end

    // Extension and fault classification by load type; illegal encodings
    // pass the raw word through so the data path stays defined
    always_comb begin
        extData  = rawWord;
        misalign = 1'b0;
        case (funct3)
            F3_LB:  extData = extendByte(byteShifted[7:0], 1'b1);
            F3_LBU: extData = extendByte(byteShifted[7:0], 1'b0);
            F3_LH: begin
                extData  = extendHalf(halfShifted[15:0], 1'b1);
                misalign = addrLow[0];
            end
            F3_LHU: begin
                extData  = extendHalf(halfShifted[15:0], 1'b0);
                misalign = addrLow[0];
            end
            F3_LW:  misalign = (addrLow != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, result mux, register-file
// write port (mirrored as the EX forwarding source), load fault flag and
// the 64-bit retired-instruction counter.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memValid,
    input  logic                     memRegWrite,
    input  logic [REG_IDX_WIDTH-1:0] memRd,
    input  logic [1:0]               memResultSel,
    input  logic [2:0]               memFunct3,
    input  logic [1:0]               memAddrLow,
    input  logic [WORD_LEN-1:0]      memAluResult,
    input  logic [WORD_LEN-1:0]      memPcPlus4,
    input  logic [WORD_LEN-1:0]      memImm,
    input  logic [WORD_LEN-1:0]      memLoadData,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     writeEnable,
    output logic [REG_IDX_WIDTH-1:0] writeAddr,
    output logic [WORD_LEN-1:0]      writeData,
    output logic                     fwdValid,
    output logic [REG_IDX_WIDTH-1:0] fwdRd,
    output logic [WORD_LEN-1:0]      fwdData,
    output logic                     loadFault,
    output logic [63:0]              instret
);

    logic                     wbValid;
    logic                     wbRegWrite;
    logic [REG_IDX_WIDTH-1:0] wbRd;
    logic [1:0]               wbResultSel;
    logic [2:0]               wbFunct3;
    logic [1:0]               wbAddrLow;
    logic [WORD_LEN-1:0]      wbAluResult;
    logic [WORD_LEN-1:0]      wbPcPlus4;
    logic [WORD_LEN-1:0]      wbImm;
    logic [WORD_LEN-1:0]      wbLoadData;
    logic [63:0]              instretQ;

    logic [WORD_LEN-1:0]      loadExt;
    logic                     loadMisalign;
    logic                     fault;
    logic [WORD_LEN-1:0]      result;

    // MEM/WB register: stall or flush turns the WB slot into a bubble
    // rather than replaying, so each instruction appears exactly once
    always_ff @(posedge clk) begin
        if (reset) begin
            wbValid     <= 1'b0;
            wbRegWrite  <= 1'b0;
            wbRd        <= '0;
            wbResultSel <= '0;
            wbFunct3    <= '0;
            wbAddrLow   <= '0;
            wbAluResult <= '0;
            wbPcPlus4   <= '0;
            wbImm       <= '0;
            wbLoadData  <= '0;
        end else if (flush || stall) begin
            wbValid <= 1'b0;
        end else begin
            wbValid     <= memValid;
            wbRegWrite  <= memRegWrite;
            wbRd        <= memRd;
            wbResultSel <= memResultSel;
            wbFunct3    <= memFunct3;
            wbAddrLow   <= memAddrLow;
            wbAluResult <= memAluResult;
            wbPcPlus4   <= memPcPlus4;
            wbImm       <= memImm;
            wbLoadData  <= memLoadData;
        end
    end

    load_extender uLoadExt (
        .rawWord  (wbLoadData),
        .funct3   (wbFunct3),
        .addrLow  (wbAddrLow),
        .extData  (loadExt),
        .misalign (loadMisalign)
    );

    // Result mux and fault qualification; faults only matter for loads
    always_comb begin
        fault = (wbResultSel == WB_SEL_LOAD) && loadMisalign;
        case (wbResultSel)
            WB_SEL_ALU:  result = wbAluResult;
            WB_SEL_LOAD: result = loadExt;
            WB_SEL_PC4:  result = wbPcPlus4;
            default:     result = wbImm;
        endcase
    end

    // Write port and forwarding source, forced to zero in bubbles
    always_comb begin
        writeEnable = wbValid && wbRegWrite && (wbRd != '0) && !fault;
        writeAddr   = wbValid ? wbRd : '0;
        writeData   = wbValid ? result : '0;
        loadFault   = wbValid && fault;
        fwdValid    = writeEnable;
        fwdRd       = writeAddr;
        fwdData     = writeData;
        instret     = instretQ;
    end

    // Retirement counter: every non-faulting valid WB instruction counts,
    // including x0 and non-writing ones; wraps naturally at 2^64
    always_ff @(posedge clk) begin
        if (reset) begin
            instretQ <= '0;
        end else if (wbValid && !fault) begin
            instretQ <= instretQ + 64'd1;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: per-cycle expectations are queued as stimulus is
// driven and compared against the write port one cycle later.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memValid = 1'b0;
    logic        memRegWrite = 1'b0;
    logic [4:0]  memRd = '0;
    logic [1:0]  memResultSel = '0;
    logic [2:0]  memFunct3 = '0;
    logic [1:0]  memAddrLow = '0;
    logic [31:0] memAluResult = '0;
    logic [31:0] memPcPlus4 = '0;
    logic [31:0] memImm = '0;
    logic [31:0] memLoadData = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        writeEnable;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;
    logic        fwdValid;
    logic [4:0]  fwdRd;
    logic [31:0] fwdData;
    logic        loadFault;
    logic [63:0] instret;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk          (clk),
        .reset        (reset),
        .memValid     (memValid),
        .memRegWrite  (memRegWrite),
        .memRd        (memRd),
        .memResultSel (memResultSel),
        .memFunct3    (memFunct3),
        .memAddrLow   (memAddrLow),
        .memAluResult (memAluResult),
        .memPcPlus4   (memPcPlus4),
        .memImm       (memImm),
        .memLoadData  (memLoadData),
        .stall        (stall),
        .flush        (flush),
        .writeEnable  (writeEnable),
        .writeAddr    (writeAddr),
        .writeData    (writeData),
        .fwdValid     (fwdValid),
        .fwdRd        (fwdRd),
        .fwdData      (fwdData),
        .loadFault    (loadFault),
        .instret      (instret)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        fault;
        logic        retire;
        logic        isReset;
    } expEntry_t;

    expEntry_t   sbQ[$];
    int          errCount = 0;
    int          chkCount = 0;
    logic [63:0] modelRet = '0;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelLoad(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] al);
        logic [31:0] b;
        logic [31:0] h;
        b = w >> (8 * int'(al));
        h = w >> (16 * int'(al[1]));
        case (f3)
            3'b000:  return {{24{b[7]}}, b[7:0]};
            3'b100:  return {24'h0, b[7:0]};
            3'b001:  return {{16{h[15]}}, h[15:0]};
            3'b101:  return {16'h0, h[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic modelFault(input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] al);
        if (sel != 2'b01) return 1'b0;
        case (f3)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return al[0];
            3'b010:         return al != 2'b00;
            default:        return 1'b1;
        endcase
    endfunction

    // One cycle: check what the previous cycle's stimulus produced, then
    // drive new inputs at the negedge and queue what they should produce
    task automatic step(input logic rst, input logic vld, input logic rw, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] al,
                        input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                        input logic [31:0] ld, input logic stl, input logic fl);
        expEntry_t e;
        @(negedge clk);
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            if (e.isReset) modelRet = '0;
            checkVal("writeEnable", 64'(writeEnable), 64'(e.we));
            checkVal("fwdValid", 64'(fwdValid), 64'(e.we));
            checkVal("writeAddr", 64'(writeAddr), 64'(e.addr));
            checkVal("fwdRd", 64'(fwdRd), 64'(e.addr));
            if (!e.fault) begin
                checkVal("writeData", 64'(writeData), 64'(e.data));
                checkVal("fwdData", 64'(fwdData), 64'(e.data));
            end
            checkVal("loadFault", 64'(loadFault), 64'(e.fault));
            checkVal("instret", instret, modelRet);
            if (e.retire) modelRet = modelRet + 64'd1;
        end
        reset = rst; memValid = vld; memRegWrite = rw; memRd = rd; memResultSel = sel;
        memFunct3 = f3; memAddrLow = al; memAluResult = alu; memPcPlus4 = pc4;
        memImm = imm; memLoadData = ld; stall = stl; flush = fl;
        e = '{we: 1'b0, addr: 5'd0, data: 32'd0, fault: 1'b0, retire: 1'b0, isReset: rst};
        if (!rst && vld && !stl && !fl) begin
            e.fault  = modelFault(sel, f3, al);
            e.addr   = rd;
            e.data   = (sel == 2'b00) ? alu : (sel == 2'b01) ? modelLoad(ld, f3, al) :
                       (sel == 2'b10) ? pc4 : imm;
            e.we     = rw && (rd != 5'd0) && !e.fault;
            e.retire = !e.fault;
        end
        sbQ.push_back(e);
    endtask

    task automatic bubble();
        step(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic loadOp(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] al);
        step(1'b0, 1'b1, 1'b1, rd, 2'b01, f3, al, 32'hDEAD_0000, 32'h0, 32'h0, 32'h80FF_7F01, 1'b0, 1'b0);
    endtask

    initial begin
        int base;
        // reset state
        step(1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 2'b00, 32'h55, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        bubble();
        // ALU writeback
        step(1'b0, 1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 2'b00, 32'h0000_1234, 32'h44, 32'h66, 32'h0, 1'b0, 1'b0);
        // load extension
        loadOp(5'd10, 3'b000, 2'd2);
        loadOp(5'd11, 3'b100, 2'd3);
        loadOp(5'd12, 3'b001, 2'd2);
        loadOp(5'd13, 3'b101, 2'd0);
        loadOp(5'd14, 3'b010, 2'd0);
        loadOp(5'd15, 3'b000, 2'd1);
        // PC+4 and immediate
        step(1'b0, 1'b1, 1'b1, 5'd20, 2'b10, 3'b000, 2'b00, 32'h1, 32'h0000_2004, 32'h3, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 5'd21, 2'b11, 3'b010, 2'b01, 32'h1, 32'h2, 32'hFFFF_F800, 32'h0, 1'b0, 1'b0);
        // misaligned / illegal loads, then a non-load with load-like fields
        loadOp(5'd7, 3'b010, 2'd1);
        loadOp(5'd8, 3'b001, 2'd3);
        loadOp(5'd9, 3'b011, 2'd0);
        step(1'b0, 1'b1, 1'b1, 5'd22, 2'b00, 3'b111, 2'b01, 32'hCAFE, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        // x0 write and non-writing instruction still retire
        step(1'b0, 1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 2'b00, 32'hBEEF, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 5'd6, 2'b00, 3'b000, 2'b00, 32'h77, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        // three stalled cycles, then the same instruction goes through once
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b1, 5'd4, 2'b00, 3'b000, 2'b00, 32'hABCD, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 5'd4, 2'b00, 3'b000, 2'b00, 32'hABCD, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        // flush alone and flush with stall
        step(1'b0, 1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 2'b00, 32'h1111, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 2'b00, 32'h2222, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        // mixed random traffic
        for (int i = 0; i < 24; i++)
            step(1'b0, ($urandom % 4) != 0, 1'(($urandom % 8) != 0), 5'($urandom), 2'($urandom),
                 3'($urandom), 2'($urandom), $urandom, $urandom, $urandom, $urandom,
                 ($urandom % 6) == 0, ($urandom % 7) == 0);
        // bring instret to 42 with a valid instruction in WB, then reset
        bubble();
        base = int'(modelRet);
        for (int i = 0; i < 43 - base; i++)
            step(1'b0, 1'b1, 1'b1, 5'(1 + (i % 31)), 2'b00, 3'b000, 2'b00, 32'(i), 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 5'd2, 2'b00, 3'b000, 2'b00, 32'h99, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        bubble();
        // counter wrap from all ones
        bubble();
        step(1'b0, 1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 2'b00, 32'h3333, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        force dut.instretQ = 64'hFFFF_FFFF_FFFF_FFFF;
        modelRet = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instretQ;
        bubble();
        bubble();
        bubble();
        $display("Result: errors=%0d of %0d checks", errCount, chkCount);
        $finish;
    end

endmodule
